// File: rtl/uart_pkg.sv
// uart_pkg: shared state, error-code and header constants for the UART packet path
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_LEN, S_PLD, S_CHK} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_CHK, ERR_LEN, ERR_TMO} err_t;
  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;
endpackage

// File: rtl/uart_rx_pkt_parser_if.sv
// uart_rx_pkt_parser_if: received byte stream in, payload stream and packet status out
interface uart_rx_pkt_parser_if;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic       o_pld_valid;
  logic [7:0] o_pld_data;
  logic       o_pld_last;
  logic [7:0] o_pkt_len;
  logic       o_pkt_ok;
  logic       o_pkt_err;
  logic [1:0] o_err_code;
  modport master (
    output i_rx_valid, i_rx_data,
    input  o_pld_valid, o_pld_data, o_pld_last, o_pkt_len, o_pkt_ok, o_pkt_err, o_err_code
  );
  modport slave (
    input  i_rx_valid, i_rx_data,
    output o_pld_valid, o_pld_data, o_pld_last, o_pkt_len, o_pkt_ok, o_pkt_err, o_err_code
  );
endinterface

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: counts idle cycles between bytes and pulses when the gap limit is reached
module uart_gap_timer #(
  parameter int P_TIMEOUT_CYCLES = 100_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  localparam int W = $clog2(P_TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  assign o_expire = i_en & ~i_clr & (cnt == W'(P_TIMEOUT_CYCLES - 1));
  always_ff @(posedge i_clk)
    cnt <= (i_rst | i_clr | ~i_en | o_expire) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_pkt_parser.sv
// uart_rx_pkt_parser: frames 55 AA LEN PAYLOAD CHK packets, streams payload cut-through
// and reports checksum, length and inter-byte timeout errors.
module uart_rx_pkt_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] P_HDR0           = HDR0_DEF,
  parameter logic [7:0] P_HDR1           = HDR1_DEF,
  parameter int         P_MAX_LEN        = 16,
  parameter int         P_TIMEOUT_CYCLES = 100_000
) (
  input logic                 i_clk,
  input logic                 i_rst,
  uart_rx_pkt_parser_if.slave bus
);
  localparam logic [7:0] MAX_LEN = 8'(P_MAX_LEN);
  state_t     state;
  logic [7:0] sum;
  logic [7:0] cnt;
  logic [7:0] d;
  logic       expire;
  assign d = bus.i_rx_data;
  uart_gap_timer #(.P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)) u_gap_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (state != S_IDLE),
    .i_clr   (bus.i_rx_valid),
    .o_expire(expire)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      sum             <= '0;
      cnt             <= '0;
      bus.o_pld_valid <= 1'b0;
      bus.o_pld_data  <= '0;
      bus.o_pld_last  <= 1'b0;
      bus.o_pkt_len   <= '0;
      bus.o_pkt_ok    <= 1'b0;
      bus.o_pkt_err   <= 1'b0;
      bus.o_err_code  <= ERR_NONE;
    end else begin
      bus.o_pld_valid <= 1'b0;
      bus.o_pld_last  <= 1'b0;
      bus.o_pkt_ok    <= 1'b0;
      bus.o_pkt_err   <= 1'b0;
      if (bus.i_rx_valid) begin
        case (state)
          S_IDLE: state <= (d == P_HDR0) ? S_HDR1 : S_IDLE;
          S_HDR1: state <= (d == P_HDR1) ? S_LEN : (d == P_HDR0) ? S_HDR1 : S_IDLE;
          S_LEN: begin
            if (d > MAX_LEN) begin
              bus.o_pkt_err  <= 1'b1;
              bus.o_err_code <= ERR_LEN;
              state          <= S_IDLE;
            end else begin
              bus.o_pkt_len <= d;
              sum           <= d;
              cnt           <= d;
              state         <= (d == 8'd0) ? S_CHK : S_PLD;
            end
          end
          S_PLD: begin
            bus.o_pld_valid <= 1'b1;
            bus.o_pld_data  <= d;
            bus.o_pld_last  <= (cnt == 8'd1);
            sum             <= sum + d;
            cnt             <= cnt - 8'd1;
            state           <= (cnt == 8'd1) ? S_CHK : S_PLD;
          end
          S_CHK: begin
            bus.o_pkt_ok  <= (d == sum);
            bus.o_pkt_err <= (d != sum);
            if (d != sum) bus.o_err_code <= ERR_CHK;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (expire) begin
        // a stalled header is just noise, so only abort a packet once LEN is pending
        if (state != S_HDR1) begin
          bus.o_pkt_err  <= 1'b1;
          bus.o_err_code <= ERR_TMO;
        end
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// tb_uart_rx_pkt_parser: directed and random packets checked against an expected-event scoreboard
module tb_uart_rx_pkt_parser;
  localparam int TMO  = 50;
  localparam int MAXL = 16;
  localparam int K_PLD = 0, K_OK = 1, K_ERR = 2;
  typedef struct {int kind; int data; int last; int code; int len; int cyc;} ev_t;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   cyc = 0, n_run = 0, n_fail = 0, force_gap = -1, last_code = 0;
  ev_t  exp_q[$];
  uart_rx_pkt_parser_if bus();
  uart_rx_pkt_parser #(.P_MAX_LEN(MAXL), .P_TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, want, cyc);
    end
  endtask
  task automatic push(input int kind, input int data, input int last, input int code, input int len, input int c);
    ev_t w;
    w = '{kind, data, last, code, len, c};
    exp_q.push_back(w);
  endtask
  function automatic int gap();
    return force_gap >= 0 ? force_gap : ($urandom_range(0, 7) == 0 ? TMO - 1 : int'($urandom_range(0, 3)));
  endfunction
  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask
  task automatic xfer(input logic [7:0] b, input int g, output int e);
    idle(g);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge i_clk); #1;
    e = cyc;
    bus.i_rx_valid = 1'b0;
  endtask
  task automatic tmo(input int e, input int len);
    push(K_ERR, 0, 0, 3, len, e + TMO);
    idle(TMO + 5);
  endtask
  task automatic pulse_rst();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    last_code = 0;
  endtask
  // mode 0 good, 1 bad checksum, 3 timeout after `cut` payload bytes (-1: before LEN)
  task automatic pkt(input logic [7:0] len, input logic [7:0] pl[$], input int mode, input int cut, input bit resync);
    int e;
    logic [7:0] sum;
    if (resync) xfer(8'h55, gap(), e);
    xfer(8'h55, gap(), e);
    xfer(8'hAA, gap(), e);
    if (mode == 3 && cut < 0) begin tmo(e, -1); return; end
    xfer(len, gap(), e);
    if (int'(len) > MAXL) begin push(K_ERR, 0, 0, 2, -1, e); return; end
    sum = len;
    for (int i = 0; i < int'(len); i++) begin
      if (mode == 3 && i == cut) begin tmo(e, len); return; end
      xfer(pl[i], gap(), e);
      sum += pl[i];
      push(K_PLD, pl[i], int'(i == int'(len) - 1), 0, len, e);
    end
    if (mode == 3) begin tmo(e, len); return; end
    xfer(mode == 1 ? sum + 8'($urandom_range(1, 255)) : sum, gap(), e);
    push(mode == 1 ? K_ERR : K_OK, 0, 0, mode == 1 ? 1 : 0, len, e);
  endtask
  always @(negedge i_clk) begin
    ev_t w;
    int  k;
    if (bus.o_pld_valid || bus.o_pkt_ok || bus.o_pkt_err) begin
      k = bus.o_pld_valid ? K_PLD : bus.o_pkt_ok ? K_OK : K_ERR;
      check("one_strobe", 32'(bus.o_pld_valid) + 32'(bus.o_pkt_ok) + 32'(bus.o_pkt_err), 1);
      if (exp_q.size() == 0) check("spurious_event", k, 32'hDEAD);
      else begin
        w = exp_q.pop_front();
        check("ev_kind", k, w.kind);
        check("ev_cycle", cyc, w.cyc);
        if (w.kind == K_PLD) begin
          check("pld_data", bus.o_pld_data, w.data);
          check("pld_last", bus.o_pld_last, w.last);
        end
        if (w.len >= 0) check("pkt_len", bus.o_pkt_len, w.len);
        if (w.kind == K_ERR) last_code = w.code;
        check("err_code", bus.o_err_code, last_code);
      end
    end
  end
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int e, mode, len;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    idle(3);
    i_rst = 1'b0;
    check("rst_outputs", {bus.o_pld_valid, bus.o_pld_last, bus.o_pkt_ok, bus.o_pkt_err,
                          bus.o_err_code, bus.o_pkt_len, bus.o_pld_data}, 0);
    q = '{8'h11, 8'h22, 8'h33};
    pkt(8'd3, q, 0, 0, 0);
    pkt(8'd3, q, 1, 0, 0);
    q.delete();
    pkt(8'h20, q, 0, 0, 0);
    q = '{8'hC4, 8'h5A};
    pkt(8'd2, q, 0, 0, 0);
    force_gap = 0;
    xfer(8'h00, 0, e);
    q.delete();
    pkt(8'd0, q, 0, 0, 1);
    force_gap = -1;
    q = '{8'h7E, 8'h00};
    pkt(8'd2, q, 3, 1, 0);
    force_gap = TMO - 1;
    q = '{8'h01, 8'hFF};
    pkt(8'd2, q, 0, 0, 0);
    force_gap = -1;
    xfer(8'h55, 0, e);
    xfer(8'hAA, 0, e);
    xfer(8'h04, 0, e);
    xfer(8'h01, 0, e); push(K_PLD, 8'h01, 0, 0, 4, e);
    xfer(8'h02, 0, e); push(K_PLD, 8'h02, 0, 0, 4, e);
    pulse_rst();
    check("midrst_outputs", {bus.o_pld_valid, bus.o_pkt_ok, bus.o_pkt_err, bus.o_err_code, bus.o_pkt_len}, 0);
    q = '{8'h09};
    pkt(8'd1, q, 0, 0, 0);
    for (int p = 0; p < 60; p++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        xfer(b == 8'h55 ? 8'h00 : b, gap(), e);
      end
      mode = $urandom_range(0, 9);
      len  = (mode == 6) ? $urandom_range(MAXL + 1, 255) : $urandom_range(0, MAXL);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      if (mode == 8) begin
        xfer(8'h55, gap(), e);
        if ($urandom_range(0, 1) == 1) idle(TMO + 5);
        else begin
          b = 8'($urandom);
          xfer((b == 8'h55 || b == 8'hAA) ? 8'h00 : b, gap(), e);
        end
      end else if (mode == 7) pkt(8'(len), q, 3, int'($urandom_range(0, len + 1)) - 1, 0);
      else pkt(8'(len), q, (mode == 5) ? 1 : 0, 0, mode == 9);
    end
    idle(TMO + 5);
    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_pkt_parser.md
# uart_rx_pkt_parser

Byte-level packet parser sitting directly downstream of `uart_rx`; it consumes that block's `o_uart_rx_valid`/`o_uart_rx_data` byte stream. It frames packets of the form `0x55 0xAA LEN PAYLOAD[LEN] CHK`, streams payload bytes out with a last marker, and reports per-packet success or error. Errors covered are checksum, over-length and inter-byte timeout. It runs in the UART user clock domain, alongside `uart_tx`/`uart_rx`.

## Interface
- `P_HDR0`, 8'h55: first header byte.
- `P_HDR1`, 8'hAA: second header byte.
- `P_MAX_LEN`, 16: maximum legal LEN (1..255).
- `P_TIMEOUT_CYCLES`, 100_000: maximum idle gap, in clock cycles, between bytes inside a packet.
- `i_clk`, in, 1: UART user clock. This is the one clock.
- `i_rst`, in, 1: reset, synchronous and active-high.
- `i_rx_valid`, in, 1: one-cycle strobe per received byte, from `uart_rx`.
- `i_rx_data`, in, 8: received byte, qualified by `i_rx_valid`.
- `o_pld_valid`, out, 1: payload byte strobe.
- `o_pld_data`, out, 8: payload byte.
- `o_pld_last`, out, 1: marks the final payload byte; valid with `o_pld_valid`.
- `o_pkt_len`, out, 8: LEN of the current/last packet; updated when LEN is accepted.
- `o_pkt_ok`, out, 1: one-cycle pulse when a packet is accepted.
- `o_pkt_err`, out, 1: one-cycle pulse when a packet is aborted.
- `o_err_code`, out, 2: 1 = checksum, 2 = length, 3 = timeout. Updated with `o_pkt_err` and held afterwards.

## Operation
- Reset: all outputs 0. State = S_IDLE. Checksum accumulator, payload counter and timeout counter are 0.
- Only cycles with `i_rx_valid=1` advance the FSM. Bytes arriving when no packet is in progress are never buffered.
- **S_IDLE**:
  - byte == P_HDR0 → S_HDR1.
  - any other byte → stay in S_IDLE.
- **S_HDR1**:
  - byte == P_HDR1 → S_LEN.
  - byte == P_HDR0 → stay in S_HDR1 (resync).
  - any other byte → S_IDLE. No error is reported.
- **S_LEN**:
  - LEN > P_MAX_LEN → pulse `o_pkt_err` with code 2, go to S_IDLE.
  - LEN == 0 → S_CHK.
  - otherwise → S_PLD.
  - On every accepted LEN the checksum is set to LEN and the payload counter to LEN.
- **S_PLD**:
  - Each byte is emitted on `o_pld_*`, added to the checksum (8-bit, mod 256) and decrements the counter.
  - The byte taken when the counter reaches 1 carries `o_pld_last`; the FSM then goes to S_CHK.
- **S_CHK**:
  - byte == checksum → `o_pkt_ok`.
  - otherwise → `o_pkt_err` with code 1.
  - Either way → S_IDLE.
  - Checksum definition: LEN + sum of payload bytes, truncated to 8 bits.
- Payload is cut-through: bytes are forwarded before the checksum is known. The downstream stage must discard the whole packet on `o_pkt_err`.
- **Timeout**:
  - The counter runs in S_HDR1, S_LEN, S_PLD and S_CHK, and clears on every `i_rx_valid`.
  - On reaching P_TIMEOUT_CYCLES-1 without a byte: pulse `o_pkt_err` with code 3 and go to S_IDLE.
  - Exception: a timeout in S_HDR1 returns to S_IDLE silently, with no error.
- Simultaneous `i_rx_valid` and timeout expiry: the byte wins. It is processed normally and the counter clears.

## Timing
- All outputs are registered.
- `o_pld_*` is asserted 1 cycle after the `i_rx_valid` carrying the payload byte.
- `o_pkt_ok`/`o_pkt_err` are asserted 1 cycle after the terminating byte or the timeout expiry.
- Outputs need no handshake: every pulse lasts exactly one cycle and there is no backpressure.
- Reset mid-packet: in the next cycle the FSM is in S_IDLE, all pulses are 0, and no ok/err is reported for the aborted packet.
- Counter width is $clog2(P_TIMEOUT_CYCLES). The payload counter is 8 bits and cannot wrap, because LEN ≤ P_MAX_LEN ≤ 255.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding S_IDLE..S_CHK, 3 bits;
  - error-code constants ERR_NONE/ERR_CHK/ERR_LEN/ERR_TMO;
  - default header constants.
- Sub-module `uart_gap_timer` holds the timeout counter.
  - Inputs: enable, clear.
  - Output: one-cycle expiry pulse.
  - Parameter: P_TIMEOUT_CYCLES.
- FSM, checksum and output registers stay in the top module.

## Test plan
- Good packet: send `55 AA 03 11 22 33 69` → `o_pld_data` 11, 22, 33, with `o_pld_last` on 33; `o_pkt_ok` pulses once; `o_pkt_len`=3.
- Bad checksum: send `55 AA 03 11 22 33 68` → payload is streamed, then `o_pkt_err` pulses with `o_err_code`=1.
- Over-length (P_MAX_LEN=16): send `55 AA 20` → `o_pkt_err` with code 2 and no `o_pld_valid`. A following good packet is accepted.
- Resync and empty packet: send `00 55 55 AA 00 00` → zero payload strobes, `o_pkt_ok` pulses.
- Timeout (P_TIMEOUT_CYCLES=50): send `55 AA 02 7E` then nothing → `o_pkt_err` with code 3, 50 cycles after the `7E` strobe. A gap of exactly 49 cycles followed by a byte does not time out.
- Reset mid-payload: send `55 AA 04 01 02`, assert `i_rst` for 1 cycle, then send `55 AA 01 09 0A` → only payload 09 follows, with `o_pkt_ok` and no error pulse.
